// File: rtl/code_sel_pkg.sv
// Shared constants for the code-to-selector encoder: widths, code table, output-register state.
package code_sel_pkg;
  localparam int CODE_W    = 8;
  localparam int SEL_W     = 2;
  localparam int NUM_CODES = 4;

  // Entry i holds the code emitted for selector i.
  localparam logic [NUM_CODES-1:0][CODE_W-1:0] CODE_TABLE = {8'hBC, 8'hAA, 8'hBB, 8'hA0};

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/code_sel_lut.sv
// Combinational code-to-selector match; unknown or unmatched codes report a miss with sel=0.
module code_sel_lut
  import code_sel_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SEL_W-1:0]  sel,
  output logic              miss
);
  // An X/Z bit makes the equality unknown, which the if treats as false, so it falls to miss.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int i = 0; i < NUM_CODES; i++) begin
      if (code == CODE_TABLE[i]) begin
        sel  = SEL_W'(i);
        miss = 1'b0;
      end
    end
  end
endmodule

// File: rtl/code_sel_encoder.sv
// Encodes code bytes back to selectors through a one-entry valid/ready output register.
// Optional feature: define CODE_MISS_CNT_EN to enable the saturating miss counter.
module code_sel_encoder
  import code_sel_pkg::*;
#(
  parameter int HIT_CNT_W  = 16,
  parameter int MISS_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CODE_W-1:0]     in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_miss,
  input  logic                  clr_cnt,
  output logic [HIT_CNT_W-1:0]  hit_cnt,
  output logic [MISS_CNT_W-1:0] miss_cnt
);
  state_e               r_state;
  logic [SEL_W-1:0]     r_sel;
  logic                 r_miss;
  logic [HIT_CNT_W-1:0] r_hit_cnt;
  logic [SEL_W-1:0]     w_sel;
  logic                 w_miss;
  logic                 w_in_fire;
  logic                 w_out_fire;

  code_sel_lut u_lut (
    .code (in_code),
    .sel  (w_sel),
    .miss (w_miss)
  );

  assign in_ready   = (r_state == EMPTY) || out_ready;
  assign out_valid  = (r_state == FULL);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign out_sel    = r_sel;
  assign out_miss   = r_miss;
  assign hit_cnt    = r_hit_cnt;

  // A simultaneous input and output transfer keeps the register FULL with the new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_sel   <= '0;
      r_miss  <= 1'b0;
    end else if (w_in_fire) begin
      r_state <= FULL;
      r_sel   <= w_sel;
      r_miss  <= w_miss;
    end else if (w_out_fire) begin
      r_state <= EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_hit_cnt <= '0;
    else if (clr_cnt)             r_hit_cnt <= '0;
    else if (w_in_fire && !w_miss) r_hit_cnt <= r_hit_cnt + 1'b1;
  end

`ifdef CODE_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_miss_cnt <= '0;
    else if (clr_cnt)                                r_miss_cnt <= '0;
    else if (w_in_fire && w_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + 1'b1;
  end

  assign miss_cnt = r_miss_cnt;
`else
  assign miss_cnt = '0;
`endif
endmodule
